multicycle_sequencer: RTL

//  Control FSM for the multi-cycle CPU datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  It issues one-hot enables to instruction memory, reg file, ALU/CPSR, data memory and PC update.
//  It waits on a variable-latency data-memory ready handshake, skips condition-failed instructions,
//  and halts or faults cleanly. It sits between instruction_decoder outputs and the datapath strobes.

---
 rtl/multicycle_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle CPU control sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB
// and issues one-hot datapath strobes, with memory-wait timeout, halt and sticky fault handling.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [2:0]       instr_class,
    input  logic             cond_pass,
    input  logic             s_bit,
    input  logic             dp_writes_rd,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             instr_en,
    output logic             rf_read_en,
    output logic             alu_en,
    output logic             cpsr_en,
    output logic             mem_en,
    output logic             mem_we,
    output logic             rf_write_en,
    output logic [1:0]       wb_sel,
    output logic             pc_en,
    output logic             pc_sel,
    output logic [2:0]       state_dbg,
    output logic [CNT_W-1:0] retired,
    output logic             fault
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [2:0] CLS_DP  = 3'd0;
    localparam logic [2:0] CLS_LDR = 3'd1;
    localparam logic [2:0] CLS_STR = 3'd2;
    localparam logic [2:0] CLS_B   = 3'd3;
    localparam logic [2:0] CLS_BL  = 3'd4;

    // Last wait count tolerated before a stalled memory access is declared a fault.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [2:0]       class_q, class_d;
    logic             s_q, s_d;
    logic             wr_q, wr_d;
    logic             exec_q, exec_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q    <= S_FETCH;
            class_q    <= 3'd0;
            s_q        <= 1'b0;
            wr_q       <= 1'b0;
            exec_q     <= 1'b0;
            wait_cnt_q <= 8'd0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            class_q    <= class_d;
            s_q        <= s_d;
            wr_q       <= wr_d;
            exec_q     <= exec_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        s_d        = s_q;
        wr_d       = wr_q;
        exec_d     = exec_q;
        wait_cnt_d = wait_cnt_q;
        retired_d  = retired_q;
        case (state_q)
            S_FETCH: state_d = halt_req ? S_HALT : S_DECODE;
            S_DECODE: begin
                class_d = instr_class;
                s_d     = s_bit;
                wr_d    = dp_writes_rd;
                exec_d  = cond_pass;
                // Undefined classes fault even when the condition fails.
                if (instr_class >= 3'd5) begin
                    state_d = S_FAULT;
                end else if (!cond_pass) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: state_d = (class_q == CLS_LDR || class_q == CLS_STR) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ready) begin
                    state_d    = S_WB;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = S_FAULT;
                    wait_cnt_d = 8'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_WB: begin
                if (exec_q) begin
                    retired_d = retired_q + CNT_W'(1);
                end
                state_d = S_FETCH;
            end
            S_HALT: if (!halt_req) state_d = S_FETCH;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are decoded from the state register and held low while reset is asserted.
    always_comb begin
        instr_en    = 1'b0;
        rf_read_en  = 1'b0;
        alu_en      = 1'b0;
        cpsr_en     = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        rf_write_en = 1'b0;
        wb_sel      = 2'd0;
        pc_en       = 1'b0;
        pc_sel      = 1'b0;
        if (nreset) begin
            case (state_q)
                S_FETCH:  instr_en = !halt_req;
                S_DECODE: rf_read_en = 1'b1;
                S_EXEC: begin
                    alu_en  = 1'b1;
                    cpsr_en = (class_q == CLS_DP) && s_q;
                end
                S_MEM: begin
                    mem_en = 1'b1;
                    mem_we = (class_q == CLS_STR);
                end
                S_WB: begin
                    pc_en       = 1'b1;
                    pc_sel      = exec_q && (class_q == CLS_B || class_q == CLS_BL);
                    rf_write_en = exec_q && ((class_q == CLS_DP && wr_q) ||
                                             class_q == CLS_LDR || class_q == CLS_BL);
                    case (class_q)
                        CLS_LDR: wb_sel = 2'd1;
                        CLS_BL:  wb_sel = 2'd2;
                        default: wb_sel = 2'd0;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign state_dbg = state_q;
    assign retired   = retired_q;
    assign fault     = (state_q == S_FAULT);

endmodule
